// File: rtl/uart_rx.sv
// UART 8N1 receiver: oversampled start detection, LSB-first data recovery, FIFO write strobe and error pulses.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       sample_tick,
    input  logic       fifo_full,
    output logic [7:0] rx_data,
    output logic       fifo_wr_en,
    output logic       frame_err,
    output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s, rx_d;
    logic [TW-1:0] tick_cnt, tick_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    rx_data_n;
    logic          busy_n, wr_n, fe_n, ov_n;
`ifdef UART_RX_PARITY_EN
    logic          par_bad, par_bad_n, pe_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            rx_d        <= 1'b1;
            state       <= S_IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            rx_data     <= '0;
            busy        <= 1'b0;
            fifo_wr_en  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            rx_m        <= rx;
            rx_s        <= rx_m;
            rx_d        <= rx_s;
            state       <= state_n;
            tick_cnt    <= tick_cnt_n;
            bit_idx     <= bit_idx_n;
            shift       <= shift_n;
            rx_data     <= rx_data_n;
            busy        <= busy_n;
            fifo_wr_en  <= wr_n;
            frame_err   <= fe_n;
            overrun_err <= ov_n;
`ifdef UART_RX_PARITY_EN
            par_bad     <= par_bad_n;
            parity_err  <= pe_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        rx_data_n  = rx_data;
        busy_n     = busy;
        wr_n       = 1'b0;
        fe_n       = 1'b0;
        ov_n       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n  = par_bad;
        pe_n       = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                // Edge-triggered only: a line held low cannot start a new frame
                if (rx_d && !rx_s) begin
                    tick_cnt_n = '0;
                    busy_n     = 1'b1;
                    state_n    = S_START;
                end
            end
            S_START: begin
                if (sample_tick) begin
                    if (tick_cnt == HALF) begin
                        if (!rx_s) begin
                            tick_cnt_n = '0;
                            bit_idx_n  = '0;
                            state_n    = S_DATA;
                        end else begin
                            busy_n  = 1'b0;
                            state_n = S_IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (sample_tick) begin
                    if (tick_cnt == LAST) begin
                        shift_n    = {rx_s, shift[7:1]};
                        tick_cnt_n = '0;
                        bit_idx_n  = bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = S_PARITY;
`else
                            state_n = S_STOP;
`endif
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample_tick) begin
                    if (tick_cnt == LAST) begin
                        par_bad_n  = ^{shift, rx_s};
                        tick_cnt_n = '0;
                        state_n    = S_STOP;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (sample_tick) begin
                    if (tick_cnt == LAST) begin
                        // Leave at mid-stop so a short stop bit still resynchronizes
                        busy_n  = 1'b0;
                        state_n = S_IDLE;
                        if (!rx_s) begin
                            fe_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            pe_n = 1'b1;
`endif
                        end else if (fifo_full) begin
                            ov_n = 1'b1;
                        end else begin
                            wr_n      = 1'b1;
                            rx_data_n = shift;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frame, false start, framing, overrun, back-to-back, mid-frame reset.
// Parity cases are added when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       sample_tick = 1'b0;
    logic       fifo_full = 1'b0;
    logic [7:0] rx_data;
    logic       fifo_wr_en, frame_err, overrun_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, multi_cnt = 0;
    logic [7:0] wr_q[$];
    logic [1:0] tdiv = 2'd0;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .sample_tick(sample_tick),
        .fifo_full(fifo_full),
        .rx_data(rx_data),
        .fifo_wr_en(fifo_wr_en),
        .frame_err(frame_err),
        .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks, updated on the falling edge so it is stable at posedge
    always @(negedge clk) begin
        tdiv        <= tdiv + 2'd1;
        sample_tick <= (tdiv == 2'd3);
    end

    always @(negedge clk) begin
        if (!rst) begin
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_cnt <= pe_cnt + 1;
            if (int'(fifo_wr_en) + int'(frame_err) + int'(overrun_err) + int'(parity_err) > 1)
                multi_cnt <= multi_cnt + 1;
`else
            if (int'(fifo_wr_en) + int'(frame_err) + int'(overrun_err) > 1)
                multi_cnt <= multi_cnt + 1;
`endif
            if (fifo_wr_en) begin
                wr_cnt <= wr_cnt + 1;
                wr_q.push_back(rx_data);
            end
            if (frame_err) fe_cnt <= fe_cnt + 1;
            if (overrun_err) ov_cnt <= ov_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (sample_tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        #1 rx = b;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_ticks, input logic stop_val);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
        send_bit(^d, 16);
`endif
        send_bit(stop_val, stop_ticks);
    endtask

    initial begin
        logic [7:0] b;
        int w0;

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        send_bit(1'b1, 8);

        // Good frame 0xA5
        send_frame(8'hA5, 16, 1'b1);
        send_bit(1'b1, 4);
        @(negedge clk);
        check("good_wr_cnt", 32'(wr_cnt), 32'd1);
        check("good_data", 32'(wr_q.size() > 0 ? wr_q[0] : 8'hxx), 32'hA5);
        check("good_rx_data_held", 32'(rx_data), 32'hA5);
        check("good_busy", 32'(busy), 32'h0);
        check("good_fe", 32'(fe_cnt), 32'd0);
        check("good_ov", 32'(ov_cnt), 32'd0);

        // False start: low for 4 ticks
        #1 rx = 1'b0;
        wait_ticks(2);
        @(negedge clk);
        check("false_busy_high", 32'(busy), 32'h1);
        wait_ticks(2);
        #1 rx = 1'b1;
        wait_ticks(4);
        @(negedge clk);
        check("false_busy_low", 32'(busy), 32'h0);
        send_bit(1'b1, 20);
        check("false_wr_cnt", 32'(wr_cnt), 32'd1);
        check("false_fe", 32'(fe_cnt), 32'd0);

        // Framing error 0x3C, then break
        send_frame(8'h3C, 16, 1'b0);
        send_bit(1'b0, 40);
        @(negedge clk);
        check("frame_fe_cnt", 32'(fe_cnt), 32'd1);
        check("frame_no_write", 32'(wr_cnt), 32'd1);
        check("frame_no_retrigger", 32'(busy), 32'h0);
        send_bit(1'b1, 16);
        @(negedge clk);
        check("frame_idle_busy", 32'(busy), 32'h0);
        check("frame_fe_stable", 32'(fe_cnt), 32'd1);

        // Overrun 0x5A
        fifo_full = 1'b1;
        send_frame(8'h5A, 16, 1'b1);
        fifo_full = 1'b0;
        send_bit(1'b1, 4);
        @(negedge clk);
        check("ovr_cnt", 32'(ov_cnt), 32'd1);
        check("ovr_no_write", 32'(wr_cnt), 32'd1);
        check("ovr_rx_data_kept", 32'(rx_data), 32'hA5);

        // Back-to-back with short stop bit on 0x81
        wr_q.delete();
        w0 = wr_cnt;
        send_frame(8'h00, 16, 1'b1);
        send_frame(8'hFF, 16, 1'b1);
        send_frame(8'h81, 9, 1'b1);
        send_frame(8'h42, 16, 1'b1);
        send_bit(1'b1, 4);
        @(negedge clk);
        check("b2b_count", 32'(wr_cnt - w0), 32'd4);
        check("b2b_0", 32'(wr_q.size() > 0 ? wr_q[0] : 8'hxx), 32'h00);
        check("b2b_1", 32'(wr_q.size() > 1 ? wr_q[1] : 8'hxx), 32'hFF);
        check("b2b_2", 32'(wr_q.size() > 2 ? wr_q[2] : 8'hxx), 32'h81);
        check("b2b_3", 32'(wr_q.size() > 3 ? wr_q[3] : 8'hxx), 32'h42);

        // Reset during data bit 4 of 0xC3
        b = 8'hC3;
        w0 = wr_cnt;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(b[i], 16);
        send_bit(b[4], 8);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        rx = 1'b1;
        send_bit(1'b1, 20);
        @(negedge clk);
        check("midrst_no_write", 32'(wr_cnt - w0), 32'd0);
        check("midrst_no_fe", 32'(fe_cnt), 32'd1);
        wr_q.delete();
        send_frame(8'h7E, 16, 1'b1);
        send_bit(1'b1, 4);
        @(negedge clk);
        check("post_rst_count", 32'(wr_cnt - w0), 32'd1);
        check("post_rst_data", 32'(wr_q.size() > 0 ? wr_q[0] : 8'hxx), 32'h7E);

`ifdef UART_RX_PARITY_EN
        // Wrong parity on 0x96 (even parity bit would be 0)
        b = 8'h96;
        w0 = wr_cnt;
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(b[i], 16);
        send_bit(~(^b), 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 4);
        @(negedge clk);
        check("par_err_cnt", 32'(pe_cnt), 32'd1);
        check("par_no_write", 32'(wr_cnt - w0), 32'd0);
        check("par_rx_data_kept", 32'(rx_data), 32'h7E);
`endif

        check("pulses_exclusive", 32'(multi_cnt), 32'd0);
        check("final_ov_cnt", 32'(ov_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
